// File: rtl/td4_sequencer_pkg.sv
// Shared types and constants for the TD4 instruction sequencer.
package td4_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned IMM_W = 4;

  localparam logic [OP_W-1:0] OP_JNC = 4'b1110;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_e;

endpackage

// File: rtl/td4_sequencer_if.sv
// Program ROM fetch port: req/ack handshake with address and instruction byte.
interface td4_sequencer_if #(
  parameter int unsigned PC_W = 4
);

  logic [PC_W-1:0] rom_addr;
  logic            rom_req;
  logic            rom_ack;
  logic [7:0]      rom_data;

  modport master (
    output rom_addr,
    output rom_req,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_req,
    output rom_ack,
    output rom_data
  );

endinterface

// File: rtl/td4_sequencer_pc.sv
// Program counter: load has priority over increment; increment wraps modulo 2^PC_W.
module td4_pc #(
  parameter int unsigned     PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/td4_sequencer.sv
// TD4 instruction sequencer: PC, IR and carry flag with fetch/execute FSM.
// Optional self-jump halt detection is enabled by defining TD4_SEQ_HALT_DETECT_EN.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned     PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  td4_sequencer_if.master   rom,
  output logic [OP_W-1:0]   op,
  output logic [IMM_W-1:0]  imm,
  output logic              cflag,
  input  logic              ld_pc_n,
  input  logic              alu_carry,
  output logic              exec,
  output logic              busy,
  output logic              halted
);

  state_e          state_q;
  logic [7:0]      ir_q;
  logic            cflag_q;
  logic            step_pend_q;
  logic            rom_req_q;
  logic            exec_q;
  logic            busy_q;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] imm_ext;
  logic            halt_hit;
  logic            pc_upd;

  assign imm_ext = PC_W'(ir_q[IMM_W-1:0]);

`ifdef TD4_SEQ_HALT_DETECT_EN
  logic halted_q;
  assign halt_hit = (ir_q[7:4] == OP_JMP) && (imm_ext == pc);
  assign halted   = halted_q;
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // PC only moves on the closing edge of a non-halting EXEC cycle.
  assign pc_upd = (state_q == ST_EXEC) && !halt_hit;

  td4_pc #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (pc_upd && ld_pc_n),
    .load_i    (pc_upd && !ld_pc_n),
    .load_val_i(imm_ext),
    .pc_o      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      cflag_q     <= 1'b0;
      step_pend_q <= 1'b0;
      rom_req_q   <= 1'b0;
      exec_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef TD4_SEQ_HALT_DETECT_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      if (step && !run) begin
        step_pend_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          // Later assignment wins so a step seen on this edge is consumed, not re-latched.
          if (run || step_pend_q || step) begin
            state_q     <= ST_FETCH;
            step_pend_q <= 1'b0;
            rom_req_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (rom.rom_ack) begin
            ir_q      <= rom.rom_data;
            state_q   <= ST_EXEC;
            rom_req_q <= 1'b0;
            exec_q    <= 1'b1;
          end
        end
        ST_EXEC: begin
          cflag_q <= alu_carry;
          exec_q  <= 1'b0;
`ifdef TD4_SEQ_HALT_DETECT_EN
          if (halt_hit) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
          end else
`endif
          if (run) begin
            state_q   <= ST_FETCH;
            rom_req_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom.rom_addr = pc;
  assign rom.rom_req  = rom_req_q;
  assign op           = ir_q[7:4];
  assign imm          = ir_q[IMM_W-1:0];
  assign cflag        = cflag_q;
  assign exec         = exec_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: single-step vector table, delayed ack,
// reset mid-fetch, free-run, and halt detection when TD4_SEQ_HALT_DETECT_EN is defined.
module tb_td4_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic [3:0] op;
  logic [3:0] imm;
  logic       cflag;
  logic       ld_pc_n;
  logic       alu_carry;
  logic       exec;
  logic       busy;
  logic       halted;

  logic       auto_ack;
  logic       man_ack;
  logic [7:0] rom_mem [16];

  int checks;
  int errors;
  int exec_cnt;

  td4_sequencer_if #(.PC_W(4)) rif ();

  assign rif.rom_ack  = auto_ack ? rif.rom_req : man_ack;
  assign rif.rom_data = rom_mem[rif.rom_addr];

  td4_sequencer #(
    .PC_W    (4),
    .RESET_PC(4'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .step     (step),
    .rom      (rif),
    .op       (op),
    .imm      (imm),
    .cflag    (cflag),
    .ld_pc_n  (ld_pc_n),
    .alu_carry(alu_carry),
    .exec     (exec),
    .busy     (busy),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each accepted fetch pushes the bench's own expectation; each exec pops it.
  typedef struct {
    logic [3:0] pc;
    logic [7:0] ir;
  } sb_t;

  sb_t        sbq [$];
  logic [3:0] model_pc;
  logic       model_cflag;
  logic       prev_exec;

  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      model_pc    = 4'h0;
      model_cflag = 1'b0;
      prev_exec   = 1'b0;
      sbq.delete();
    end else begin
      check("mon_cflag", cflag, model_cflag);
      check("mon_busy", busy, rif.rom_req | exec);
      check("mon_exec_b2b", prev_exec & exec, 0);
      if (rif.rom_req && rif.rom_ack) begin
        check("mon_fetch_addr", rif.rom_addr, model_pc);
        e.pc = model_pc;
        e.ir = rom_mem[model_pc];
        sbq.push_back(e);
      end
      if (exec) begin
        exec_cnt++;
        check("mon_sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("mon_exec_ir", {op, imm}, e.ir);
          check("mon_exec_pc", rif.rom_addr, e.pc);
          model_pc = ld_pc_n ? e.pc + 4'h1 : e.ir[3:0];
        end
        model_cflag = alu_carry;
      end
      prev_exec = exec;
    end
  end

  task automatic step_pulse();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    check(name, busy, 0);
  endtask

  typedef struct {
    logic [7:0] instr;
    logic       ld_n;
    logic       carry;
    logic [3:0] exp_pc;
    logic       exp_cf;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [3:0] cur_pc;
    int         e0;
    int         gap;

    checks   = 0;
    errors   = 0;
    exec_cnt = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    ld_pc_n  = 1'b1;
    alu_carry = 1'b0;
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h31;

    tbl[0] = '{8'hF5, 1'b0, 1'b0, 4'h5, 1'b0};
    tbl[1] = '{8'h31, 1'b1, 1'b1, 4'h6, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 1'b0, 4'h7, 1'b0};
    tbl[3] = '{8'hEC, 1'b0, 1'b1, 4'hC, 1'b1};
    tbl[4] = '{8'h31, 1'b1, 1'b0, 4'hD, 1'b0};
    tbl[5] = '{8'hFF, 1'b0, 1'b0, 4'hF, 1'b0};
    tbl[6] = '{8'h31, 1'b1, 1'b1, 4'h0, 1'b1};
    tbl[7] = '{8'h73, 1'b0, 1'b1, 4'h3, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", rif.rom_addr, 4'h0);
    check("rst_ir", {op, imm}, 8'h00);
    check("rst_cflag", cflag, 0);
    check("rst_req", rif.rom_req, 0);
    check("rst_exec", exec, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single-step vector table
    cur_pc = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rom_mem[cur_pc] = tbl[i].instr;
      ld_pc_n   = tbl[i].ld_n;
      alu_carry = tbl[i].carry;
      auto_ack  = 1'b1;
      e0 = exec_cnt;
      step_pulse();
      wait_idle("step_idle");
      check("step_pc", rif.rom_addr, tbl[i].exp_pc);
      check("step_cflag", cflag, tbl[i].exp_cf);
      check("step_ir", {op, imm}, tbl[i].instr);
      check("step_exec_count", exec_cnt - e0, 1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("step_no_req", rif.rom_req, 0);
      end
      cur_pc = tbl[i].exp_pc;
    end

    // Delayed ack: three wait cycles then ack
    @(posedge clk); #1;
    auto_ack  = 1'b0;
    man_ack   = 1'b0;
    rom_mem[cur_pc] = 8'h9A;
    ld_pc_n   = 1'b1;
    alu_carry = 1'b1;
    e0 = exec_cnt;
    step_pulse();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) man_ack = 1'b1;
      @(negedge clk);
      check("dly_req", rif.rom_req, 1);
      check("dly_addr", rif.rom_addr, cur_pc);
      check("dly_exec_low", exec, 0);
      if (i < 3) check("dly_ir_held", {op, imm}, 8'h73);
      @(posedge clk); #1;
    end
    man_ack = 1'b0;
    @(negedge clk);
    check("dly_exec", exec, 1);
    check("dly_ir", {op, imm}, 8'h9A);
    wait_idle("dly_idle");
    check("dly_pc", rif.rom_addr, 4'h4);
    check("dly_cflag", cflag, 1);
    check("dly_exec_count", exec_cnt - e0, 1);

    // Reset mid-FETCH with ack arriving in the same cycle
    step_pulse();
    man_ack = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("rstf_req", rif.rom_req, 0);
    check("rstf_pc", rif.rom_addr, 4'h0);
    check("rstf_ir", {op, imm}, 8'h00);
    check("rstf_cflag", cflag, 0);
    check("rstf_busy", busy, 0);
    @(posedge clk); #1 man_ack = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstf_after_ir", {op, imm}, 8'h00);
    check("rstf_after_busy", busy, 0);

    // Free-run: MOV A,1 everywhere, same-cycle ack
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h31;
    @(posedge clk); #1;
    auto_ack  = 1'b1;
    ld_pc_n   = 1'b1;
    alu_carry = 1'b0;
    run       = 1'b1;
    for (int k = 0; k < 17; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (!exec && k > 0) check("run_req_fetch", rif.rom_req, 1);
      end while (!exec && gap < 10);
      check("run_exec_seen", exec, 1);
      if (k > 0) check("run_gap", gap, 2);
      check("run_pc", rif.rom_addr, k % 16);
      check("run_req_exec", rif.rom_req, 0);
    end
    @(posedge clk); #1 run = 1'b0;
    e0 = exec_cnt;
    wait_idle("run_drop_idle");
    check("run_drop_execs", exec_cnt - e0, 1);
    check("run_drop_pc", rif.rom_addr, 4'h2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("run_drop_no_req", rif.rom_req, 0);
    end

`ifdef TD4_SEQ_HALT_DETECT_EN
    // Self-jump halt
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rom_mem[3] = 8'hF3;
    ld_pc_n    = 1'b1;
    run        = 1'b1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!halted && gap < 30);
    check("halt_set", halted, 1);
    check("halt_pc", rif.rom_addr, 4'h3);
    check("halt_req", rif.rom_req, 0);
    check("halt_busy", busy, 0);
    step_pulse();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("halt_stays", halted, 1);
      check("halt_no_req", rif.rom_req, 0);
      check("halt_no_exec", exec, 0);
    end
    @(posedge clk); #1 run = 1'b0; rst_n = 1'b0;
    #1 check("halt_cleared", halted, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    rom_mem[3] = 8'h31;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
- Instruction sequencer for the TD4 4-bit CPU: owns the program counter, instruction register and carry flag.
- Fetches one 8-bit instruction from program ROM via a req/ack handshake and presents op/imm to the opcode decoder.
- Issues a one-cycle execute strobe that gates register writes, then updates PC (increment or jump) and carry.
- Supports free-run and single-step operation.

Parameters:
PC_W, 4, program counter / ROM address width in bits
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = continuous fetch/execute
step  in  1  one-cycle pulse; execute exactly one instruction while run=0
rom_addr  out  PC_W  ROM address, equals pc
rom_req  out  1  fetch request
rom_ack  in  1  ROM data valid this cycle
rom_data  in  8  instruction {op[7:4], imm[3:0]}
op  out  4  current opcode to decoder
imm  out  4  current immediate to datapath
cflag  out  1  registered carry flag to decoder
ld_pc_n  in  1  decoder PC-load, active-low (0 = jump to imm)
alu_carry  in  1  adder carry-out of current instruction
exec  out  1  one-cycle execute strobe; datapath registers write only when 1
busy  out  1  1 in FETCH or EXEC
halted  out  1  self-loop halt indicator (optional feature; 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=RESET_PC; ir=8'h00; cflag=0; step_pend=0; rom_req=0; exec=0; busy=0; halted=0. Takes effect immediately mid-FETCH or mid-EXEC; any in-flight ack is discarded.
- op=ir[7:4], imm=ir[3:0], rom_addr=pc: continuous, from registers.
- step_pend: set on step=1 when run=0 in any state. Cleared on the IDLE->FETCH transition.
- IDLE:
  - rom_req=0.
  - run=1 -> FETCH. Otherwise step_pend=1 or step=1 -> FETCH.
  - run and step both high: run wins; step is not latched.
- FETCH:
  - rom_req=1; rom_addr held stable.
  - Wait indefinitely for rom_ack. On ack: ir<=rom_data, -> EXEC.
  - rom_ack while rom_req=0 is ignored.
- EXEC (exactly one cycle):
  - exec=1.
  - At the closing edge: cflag<=alu_carry. Carry is updated by every instruction, matching TD4 semantics where all ops pass the adder.
  - At the closing edge: pc<=(ld_pc_n==0) ? imm zero-extended to PC_W : pc+1, modulo 2^PC_W (15->0 at PC_W=4).
  - Next state: run=1 -> FETCH; else IDLE.
- run dropped during FETCH/EXEC: the current instruction completes (fetch, exec, PC/flag update), then IDLE.
- Throughput: 2 cycles/instruction with same-cycle ack; 2+N with N wait cycles.
- busy=1 iff state is FETCH or EXEC.
- exec never asserts outside EXEC; never two consecutive cycles.

Optional Feature:
- Macro: TD4_SEQ_HALT_DETECT_EN.
- Defined: in EXEC, if op==4'b1111 (JMP) and imm==pc, set halted=1 and go to HALT state. rom_req=0, exec=0, pc unchanged, busy=0. run/step are ignored; only reset exits HALT.
- Undefined: no HALT state; halted tied 0; self-jump loops forever.

Decomposition:
- Shared package td4_pkg: state enum (IDLE, FETCH, EXEC, HALT); opcode constants OP_JNC=4'b1110, OP_JMP=4'b1111; instruction field widths OP_W=4, IMM_W=4.
- One natural sub-module: td4_pc (PC register with load/increment/wrap, async reset to RESET_PC).
- FSM, IR and carry stay in the top.

Test Plan:
- Reset then run=1, ROM returns 8'h31 (MOV A,1) at all addresses, ack same cycle -> exec every 2nd cycle; pc 0,1,..,15,0; rom_req pattern 1,0,1,0.
- run=0, one step pulse, rom_data=8'hF5 (JMP 5), ld_pc_n=0 -> exactly one exec pulse, pc=5, back to IDLE with busy=0; no further rom_req.
- ack delayed 3 cycles -> rom_addr stable and rom_req high for 4 cycles; ir loaded only on the ack cycle; exec once.
- EXEC with alu_carry=1 -> cflag=1 next cycle; following instruction with alu_carry=0 -> cflag=0.
- rst_n low during FETCH with rom_ack arriving the same cycle -> pc=RESET_PC, ir=0, cflag=0, rom_req=0 immediately; ack ignored.
- With TD4_SEQ_HALT_DETECT_EN: ROM[3]=8'hF3, run=1 -> halted=1 after EXEC at pc=3; rom_req stays 0; run/step have no effect; only reset clears halted.
